// File: rtl/bounded_updown_counter.sv
// -----------------------------------------------------------------------------
// bounded_updown_counter
//   Up/down counter with a runtime step size, inclusive lower/upper limits and
//   four end-of-range behaviours: wrap, saturate, bounce (ping-pong) and
//   one-shot. It also provides a synchronous clear, a clamped parallel load,
//   a terminal-count pulse, a held one-shot done flag and a sticky overshoot
//   flag. It is the shared timebase/sequencer primitive for PWM, scan and
//   timer blocks.
//
// Ports
//   clk         in   1       clock, rising edge
//   reset       in   1       asynchronous reset, active-low
//   clr_i       in   1       sync clear: count<=lo, direction<=up, done/ovf<=0
//   load_i      in   1       sync load of load_val_i clamped to [lo_i,hi_i]
//   load_val_i  in   WIDTH   parallel load value
//   en_i        in   1       step enable (0 = pause, count holds)
//   dir_i       in   1       1=up, 0=down; ignored in bounce mode
//   mode_i      in   2       00 wrap, 01 saturate, 10 bounce, 11 one-shot
//   step_i      in   STEP_W  unsigned step magnitude
//   lo_i, hi_i  in   WIDTH   inclusive limits, lo_i<=hi_i expected
//   count_o     out  WIDTH   registered count
//   dir_out_o   out  1       registered effective direction
//   tc_o        out  1       registered pulse: a step reached the travel limit
//   done_o      out  1       one-shot finished (held until clr/load)
//   ovf_o       out  1       sticky: a step overshot a limit
//   cfg_err_o   out  1       combinational: lo_i > hi_i
// -----------------------------------------------------------------------------

// Protocol checker: invariants the counter must keep every cycle.
module bounded_updown_counter_chk #(
  parameter int unsigned WIDTH = 8
) (
  input logic             clk,
  input logic             reset,
  input logic             clr_i,
  input logic             load_i,
  input logic [WIDTH-1:0] lo_i,
  input logic [WIDTH-1:0] hi_i,
  input logic [WIDTH-1:0] count_o,
  input logic             tc_o,
  input logic             done_o,
  input logic             ovf_o,
  input logic             cfg_err_o
);

  // A clear lands on the lower limit with every flag cleared.
  a_clr: assert property (@(posedge clk) disable iff (!reset)
    clr_i |=> (count_o == $past(lo_i)) && !ovf_o && !done_o && !tc_o);

  // A load (without clear) drops done, tc and ovf.
  a_load: assert property (@(posedge clk) disable iff (!reset)
    (load_i && !clr_i) |=> !done_o && !tc_o && !ovf_o);

  // done and ovf only fall through clear, load or reset.
  a_done_held: assert property (@(posedge clk) disable iff (!reset)
    (done_o && !clr_i && !load_i) |=> done_o);
  a_ovf_sticky: assert property (@(posedge clk) disable iff (!reset)
    (ovf_o && !clr_i && !load_i) |=> ovf_o);

  // cfg_err mirrors the limit ordering and freezes stepping.
  a_cfg_err: assert property (@(posedge clk) disable iff (!reset)
    cfg_err_o == (lo_i > hi_i));
  a_cfg_freeze: assert property (@(posedge clk) disable iff (!reset)
    (cfg_err_o && !clr_i && !load_i) |=> !tc_o && $stable(count_o));

endmodule

module bounded_updown_counter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned STEP_W    = 4,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [WIDTH-1:0]  load_val_i,
  input  logic              en_i,
  input  logic              dir_i,
  input  logic [1:0]        mode_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic [WIDTH-1:0]  lo_i,
  input  logic [WIDTH-1:0]  hi_i,
  output logic [WIDTH-1:0]  count_o,
  output logic              dir_out_o,
  output logic              tc_o,
  output logic              done_o,
  output logic              ovf_o,
  output logic              cfg_err_o
);

  // Intermediates are wide enough that count+step and lo+step never wrap.
  localparam int unsigned EXT_W = WIDTH + STEP_W + 1;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_BOUNCE  = 2'b10;
  localparam logic [1:0] MODE_ONESHOT = 2'b11;

  localparam logic [WIDTH-1:0] RESET_COUNT = WIDTH'(RESET_VAL);

  // State registers and their next-state values.
  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_state_q, dir_state_d;
  logic             dir_out_q, dir_out_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;

  // Combinational helpers.
  logic [EXT_W-1:0] count_x_s;
  logic [EXT_W-1:0] step_x_s;
  logic [EXT_W-1:0] lo_x_s;
  logic [EXT_W-1:0] hi_x_s;
  logic [EXT_W-1:0] sum_up_s;
  logic [EXT_W-1:0] lo_plus_s;
  logic [EXT_W-1:0] diff_dn_s;
  logic             up_eff_s;
  logic             over_up_s;
  logic             land_up_s;
  logic             over_dn_s;
  logic             land_dn_s;
  logic             over_s;
  logic             limit_hit_s;
  logic             step_ok_s;
  logic             cfg_err_s;
  logic [WIDTH-1:0] load_floor_s;
  logic [WIDTH-1:0] load_clamp_s;

  // Limit comparisons, step qualification and load clamping.
  always_comb begin
    count_x_s = EXT_W'(count_q);
    step_x_s  = EXT_W'(step_i);
    lo_x_s    = EXT_W'(lo_i);
    hi_x_s    = EXT_W'(hi_i);
    sum_up_s  = count_x_s + step_x_s;
    lo_plus_s = lo_x_s + step_x_s;
    // Only used when the down step does not overshoot, so it never underflows.
    diff_dn_s = count_x_s - step_x_s;

    over_up_s = (sum_up_s > hi_x_s);
    land_up_s = (sum_up_s == hi_x_s);
    over_dn_s = (count_x_s < lo_plus_s);
    land_dn_s = (count_x_s == lo_plus_s);

    cfg_err_s = (lo_i > hi_i);

    if (mode_i == MODE_BOUNCE) begin
      up_eff_s = dir_state_q;
    end else begin
      up_eff_s = dir_i;
    end

    if (up_eff_s) begin
      over_s      = over_up_s;
      limit_hit_s = over_up_s | land_up_s;
    end else begin
      over_s      = over_dn_s;
      limit_hit_s = over_dn_s | land_dn_s;
    end

    step_ok_s = en_i & ~done_q & ~cfg_err_s & (step_i != {STEP_W{1'b0}});

    // min(max(load_val, lo), hi)
    if (load_val_i < lo_i) begin
      load_floor_s = lo_i;
    end else begin
      load_floor_s = load_val_i;
    end
    if (load_floor_s > hi_i) begin
      load_clamp_s = hi_i;
    end else begin
      load_clamp_s = load_floor_s;
    end
  end

  // Next-state selection: clear, then load, then a qualified step, else hold.
  always_comb begin
    count_d     = count_q;
    dir_state_d = dir_state_q;
    done_d      = done_q;
    ovf_d       = ovf_q;
    tc_d        = 1'b0;

    if (clr_i) begin
      count_d     = lo_i;
      dir_state_d = 1'b1;
      done_d      = 1'b0;
      ovf_d       = 1'b0;
    end else if (load_i) begin
      count_d = load_clamp_s;
      done_d  = 1'b0;
      ovf_d   = 1'b0;
    end else if (step_ok_s) begin
      tc_d  = limit_hit_s;
      ovf_d = ovf_q | over_s;

      if (!limit_hit_s) begin
        if (up_eff_s) begin
          count_d = sum_up_s[WIDTH-1:0];
        end else begin
          count_d = diff_dn_s[WIDTH-1:0];
        end
      end else if (over_s && (mode_i == MODE_WRAP)) begin
        // Wrap restarts at the opposite limit; any remainder is dropped.
        if (up_eff_s) begin
          count_d = lo_i;
        end else begin
          count_d = hi_i;
        end
      end else begin
        if (up_eff_s) begin
          count_d = hi_i;
        end else begin
          count_d = lo_i;
        end
      end

      case (mode_i)
        MODE_BOUNCE: begin
          if (limit_hit_s) begin
            dir_state_d = ~up_eff_s;
          end else begin
            dir_state_d = dir_state_q;
          end
        end
        MODE_ONESHOT: begin
          if (limit_hit_s) begin
            done_d = 1'b1;
          end else begin
            done_d = done_q;
          end
        end
        MODE_WRAP, MODE_SAT: begin
          dir_state_d = dir_state_q;
        end
        default: begin
          dir_state_d = dir_state_q;
        end
      endcase
    end else begin
      count_d = count_q;
    end

    // Report the direction that will govern the next step.
    if (mode_i == MODE_BOUNCE) begin
      dir_out_d = dir_state_d;
    end else begin
      dir_out_d = dir_i;
    end
  end

  // Counter state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q     <= RESET_COUNT;
      dir_state_q <= 1'b1;
      dir_out_q   <= 1'b1;
      tc_q        <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      count_q     <= count_d;
      dir_state_q <= dir_state_d;
      dir_out_q   <= dir_out_d;
      tc_q        <= tc_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
    end
  end

  assign count_o   = count_q;
  assign dir_out_o = dir_out_q;
  assign tc_o      = tc_q;
  assign done_o    = done_q;
  assign ovf_o     = ovf_q;
  assign cfg_err_o = cfg_err_s;

  bounded_updown_counter_chk #(
    .WIDTH (WIDTH)
  ) u_chk (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (clr_i),
    .load_i    (load_i),
    .lo_i      (lo_i),
    .hi_i      (hi_i),
    .count_o   (count_q),
    .tc_o      (tc_q),
    .done_o    (done_q),
    .ovf_o     (ovf_q),
    .cfg_err_o (cfg_err_s)
  );

endmodule
